bus_slave_port: RTL
===================

BUS_SLAVE_PORT -- requirements
Module: bus_slave_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the local memory data width.
REQ-002 The block SHALL have parameter SLAVE_MEM_ADDR_WIDTH, default 12, giving the number of serial address bits received.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  asynchronous active-low reset.
REQ-004 The block SHALL have these bus-side ports:
- wdata  in  1  serial address/write-data bit.
- mode  in  1  0 = read, 1 = write.
- mvalid  in  1  wdata bit valid this cycle.
- rdata  out  1  serial read-data bit.
- svalid  out  1  rdata bit valid this cycle.
- ready  out  1  slave idle and able to accept a new transfer.
REQ-005 The block SHALL have these memory-side ports:
- mem_addr  out  SLAVE_MEM_ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_wen  out  1  one-cycle write strobe.
- mem_ren  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_ren.

Function
REQ-006 The state machine SHALL have the states IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RD_LOAD and RDATA.
REQ-007 Serial fields SHALL be transferred LSB first, one bit per cycle in which mvalid=1.
REQ-008 In IDLE, mvalid=1 SHALL capture wdata as address bit 0, latch mode, set the bit counter to 1 and move to ADDR.
REQ-009 In ADDR, SLAVE_MEM_ADDR_WIDTH bits SHALL be shifted in, and mvalid=0 cycles SHALL pause without consuming a bit.
REQ-010 On the last address bit, the next state SHALL be WDATA if latched mode=1, otherwise MEM_RD.
REQ-011 In WDATA, DATA_WIDTH bits SHALL be shifted in (mvalid-gated); after the last bit the next state SHALL be MEM_WR.
REQ-012 MEM_WR SHALL drive mem_wen=1 for exactly one cycle with mem_addr/mem_wdata stable, then go to IDLE.
REQ-013 MEM_RD SHALL drive mem_ren=1 for exactly one cycle, then go to RD_LOAD.
REQ-014 RD_LOAD SHALL capture mem_rdata into the output shift register, then go to RDATA.
REQ-015 RDATA SHALL assert svalid=1 for exactly DATA_WIDTH consecutive cycles, presenting bits LSB first on rdata, then go to IDLE.
REQ-016 Read latency SHALL be: last address bit at cycle N, mem_ren at N+1, load at N+2, first svalid at N+3, last svalid at N+2+DATA_WIDTH.
REQ-017 Write latency SHALL be: last data bit at cycle M, mem_wen at M+1, ready=1 at M+2.
REQ-018 ready SHALL be 1 only in IDLE, and SHALL fall in the cycle after the first mvalid bit is accepted.
REQ-019 Changes on mode after the first bit SHALL be ignored until the next IDLE.
REQ-020 mvalid SHALL be ignored in MEM_WR, MEM_RD, RD_LOAD and RDATA.
REQ-021 rdata SHALL be 0 whenever svalid=0.
REQ-022 mem_addr and mem_wdata SHALL hold their last values outside the strobe cycles.
REQ-023 The bit counter SHALL be sized to max(SLAVE_MEM_ADDR_WIDTH, DATA_WIDTH) and cleared on every state change.

Reset
REQ-024 rstn=0 SHALL immediately set the state to IDLE, clear counters and shift registers, and drive svalid=0, rdata=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0 and ready=1.
REQ-025 Reset asserted mid-transfer SHALL abort the transfer with no memory strobe issued, and the first mvalid after release SHALL start a new transfer.

Structure
REQ-026 The state encodings SHALL be placed in the shared bus package bus_pkg, alongside the bus width constants.
REQ-027 The block SHALL be one flat module with no sub-modules.

Verification
REQ-028 Write: addr 0xABC and data 0x5A sent contiguously -> single mem_wen at M+1 with mem_addr=0xABC and mem_wdata=0x5A, and ready=1 at M+2.
REQ-029 Read: addr 0x123 sent with mem_rdata=0xC3 -> mem_ren at N+1 with mem_addr=0x123, then svalid for 8 cycles from N+3 with rdata 1,1,0,0,0,0,1,1.
REQ-030 Gapped write: addr 0x00F and data 0xFF sent with mvalid toggling 1/0 -> same result as contiguous, with ready=0 throughout the transfer.
REQ-031 Mode flip: mode=1 on the first bit and mode=0 afterwards -> the transfer completes as a write with no mem_ren.
REQ-032 Reset mid-read: rstn pulsed low during RDATA bit 3 -> svalid drops at once, ready=1, and a following write of 0x7F to 0x001 completes correctly.
REQ-033 Back-to-back: a read of 0x010 starts in the first cycle ready=1 after a write of 0x55 to 0x010 -> read returns 0x55 from a memory model.

Source files
------------

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared serial-bus definitions: bus width constants, slave
//                port state encodings and small elaboration helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Default widths of the serial memory bus
    localparam int BUS_DATA_WIDTH = 8;
    localparam int BUS_ADDR_WIDTH = 12;

    // Slave port state encodings
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        WDATA   = 3'd2,
        MEM_WR  = 3'd3,
        MEM_RD  = 3'd4,
        RD_LOAD = 3'd5,
        RDATA   = 3'd6
    } bus_state_t;

    // Larger of two elaboration-time integers
    function automatic int bus_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_slave_port.sv
`default_nettype none
// ============================================================================
//  Module      : bus_slave_port
//  Description : Serial bus slave. Receives an LSB-first address (and write
//                data), issues a single-cycle memory strobe, and for reads
//                returns the memory word LSB first on rdata.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH           = BUS_DATA_WIDTH,
    parameter int SLAVE_MEM_ADDR_WIDTH = BUS_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            wdata,
    input  logic                            mode,
    input  logic                            mvalid,
    output logic                            rdata,
    output logic                            svalid,
    output logic                            ready,
    output logic [SLAVE_MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_wen,
    output logic                            mem_ren,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int c_CNT_MAX = bus_max(SLAVE_MEM_ADDR_WIDTH, DATA_WIDTH);
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(SLAVE_MEM_ADDR_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_WIDTH - 1);

    bus_state_t                      r_state;
    bus_state_t                      w_state_next;
    logic [c_CNT_W-1:0]              r_cnt;
    logic                            w_cnt_en;
    logic                            r_mode;
    logic [SLAVE_MEM_ADDR_WIDTH-1:0] r_addr_sh;
    // The final data bit goes straight from wdata into mem_wdata, so only
    // DATA_WIDTH-1 bits ever need to be buffered.
    logic [DATA_WIDTH-2:0]           r_data_sh;
    logic [DATA_WIDTH-1:0]           r_rd_sh;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and Moore outputs
    always_comb begin
        w_state_next = r_state;
        w_cnt_en     = 1'b0;
        ready        = 1'b0;
        svalid       = 1'b0;
        rdata        = 1'b0;
        mem_wen      = 1'b0;
        mem_ren      = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (mvalid) begin
                    w_state_next = ADDR;
                end
            end
            ADDR: begin
                if (mvalid) begin
                    w_cnt_en = 1'b1;
                    if (r_cnt == c_ADDR_LAST) begin
                        w_state_next = r_mode ? WDATA : MEM_RD;
                    end
                end
            end
            WDATA: begin
                if (mvalid) begin
                    w_cnt_en = 1'b1;
                    if (r_cnt == c_DATA_LAST) begin
                        w_state_next = MEM_WR;
                    end
                end
            end
            MEM_WR: begin
                mem_wen      = 1'b1;
                w_state_next = IDLE;
            end
            MEM_RD: begin
                mem_ren      = 1'b1;
                w_state_next = RD_LOAD;
            end
            RD_LOAD: begin
                w_state_next = RDATA;
            end
            RDATA: begin
                svalid   = 1'b1;
                rdata    = r_rd_sh[0];
                w_cnt_en = 1'b1;
                if (r_cnt == c_DATA_LAST) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Bit counter: restarts on every state change (at 1 on entering ADDR,
    // since bit 0 is consumed in IDLE)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_state != w_state_next) begin
            r_cnt <= (w_state_next == ADDR) ? c_CNT_ONE : '0;
        end else if (w_cnt_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shift registers and memory-side address/data; mem_addr and mem_wdata
    // only change on the edge that enters a strobe state, so they hold
    // their values between transfers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode    <= 1'b0;
            r_addr_sh <= '0;
            r_data_sh <= '0;
            r_rd_sh   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (mvalid) begin
                        r_mode    <= mode;
                        r_addr_sh <= {wdata, r_addr_sh[SLAVE_MEM_ADDR_WIDTH-1:1]};
                    end
                end
                ADDR: begin
                    if (mvalid) begin
                        r_addr_sh <= {wdata, r_addr_sh[SLAVE_MEM_ADDR_WIDTH-1:1]};
                        if (r_cnt == c_ADDR_LAST && !r_mode) begin
                            mem_addr <= {wdata, r_addr_sh[SLAVE_MEM_ADDR_WIDTH-1:1]};
                        end
                    end
                end
                WDATA: begin
                    if (mvalid) begin
                        r_data_sh <= {wdata, r_data_sh[DATA_WIDTH-2:1]};
                        if (r_cnt == c_DATA_LAST) begin
                            mem_addr  <= r_addr_sh;
                            mem_wdata <= {wdata, r_data_sh};
                        end
                    end
                end
                RD_LOAD: begin
                    r_rd_sh <= mem_rdata;
                end
                RDATA: begin
                    r_rd_sh <= r_rd_sh >> 1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
